// File: rtl/slot_scheduler.sv
// ---------------------------------------------------------------------------
// slot_scheduler
//
// Sequences three one-hot design slots (driver fan-out plus 8-bit output mux).
// It produces the shared sample counter t and a sample tick from a
// programmable divider. It also drives the one-hot slot select. Every slot
// change passes through a guard gap of sel=000, so no partial output is ever
// muxed. Slots change on an explicit request, or rotate automatically after
// a programmable dwell.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_div        tick period minus 1 (0 = tick every cycle)
//   i_auto_en    enable automatic slot rotation
//   i_dwell      auto-rotate when t would reach this value; 0 disables auto
//   i_req_valid  slot-change request valid
//   i_req_slot   requested slot 0..2 (3 is illegal and simply consumed)
//   o_req_ready  request accepted when i_req_valid & o_req_ready
//   o_sel        one-hot slot select, 000 during guard
//   o_t          sample counter driven into the demux
//   o_tick       one-cycle pulse coinciding with a t update
//   o_busy       high while in guard
// ---------------------------------------------------------------------------
module slot_scheduler #(
    parameter int T_WIDTH   = 19,
    parameter int DIV_WIDTH = 16,
    parameter int GUARD     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_auto_en,
    input  logic [T_WIDTH-1:0]   i_dwell,
    input  logic                 i_req_valid,
    input  logic [1:0]           i_req_slot,
    output logic                 o_req_ready,
    output logic [2:0]           o_sel,
    output logic [T_WIDTH-1:0]   o_t,
    output logic                 o_tick,
    output logic                 o_busy
);

    // The guard counter only needs to hold GUARD-1.
    localparam int GC_W = (GUARD > 1) ? $clog2(GUARD) : 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    // Unknown indices fall back to slot0, so the select can never go multi-hot.
    function automatic logic [2:0] slot_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b001;
        endcase
        return oh;
    endfunction

    // Rotation order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] slot_next(input logic [1:0] idx);
        logic [1:0] nx;
        case (idx)
            2'd0:    nx = 2'd1;
            2'd1:    nx = 2'd2;
            default: nx = 2'd0;
        endcase
        return nx;
    endfunction

    state_t               r_state;
    logic [2:0]           r_sel;
    logic [T_WIDTH-1:0]   r_t;
    logic                 r_tick;
    logic                 r_busy;
    logic                 r_req_ready;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [GC_W-1:0]      r_gc;
    logic [1:0]           r_slot;
    logic [1:0]           r_target;

    state_t               w_state;
    logic [2:0]           w_sel;
    logic [T_WIDTH-1:0]   w_t;
    logic                 w_tick;
    logic                 w_busy;
    logic                 w_req_ready;
    logic [DIV_WIDTH-1:0] w_cnt;
    logic [GC_W-1:0]      w_gc;
    logic [1:0]           w_slot;
    logic [1:0]           w_target;
    logic                 w_div_hit;
    logic                 w_req_legal;
    logic                 w_auto_hit;
    logic                 w_enter_guard;

    // Next-state and next-output computation for the RUN/GUARD sequencer.
    always_comb begin
        w_state       = r_state;
        w_sel         = r_sel;
        w_t           = r_t;
        w_tick        = 1'b0;
        w_busy        = r_busy;
        w_req_ready   = r_req_ready;
        w_cnt         = r_cnt;
        w_gc          = r_gc;
        w_slot        = r_slot;
        w_target      = r_target;
        w_enter_guard = 1'b0;

        // ">=" lets a lowered divisor take effect immediately.
        w_div_hit   = (r_cnt >= i_div);
        w_req_legal = i_req_valid && (i_req_slot != 2'd3);
        // Auto fires on the tick that would land t on dwell; that increment is dropped.
        w_auto_hit  = i_auto_en && (i_dwell != {T_WIDTH{1'b0}}) && w_div_hit &&
                      ((r_t + {{(T_WIDTH-1){1'b0}}, 1'b1}) == i_dwell);

        case (r_state)
            ST_RUN: begin
                if (w_req_legal) begin
                    // An external request beats a same-cycle auto rotation.
                    w_target      = i_req_slot;
                    w_enter_guard = 1'b1;
                end else if (w_auto_hit) begin
                    w_target      = slot_next(r_slot);
                    w_enter_guard = 1'b1;
                end else if (w_div_hit) begin
                    w_cnt  = {DIV_WIDTH{1'b0}};
                    w_t    = r_t + {{(T_WIDTH-1){1'b0}}, 1'b1};
                    w_tick = 1'b1;
                end else begin
                    w_cnt = r_cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_GUARD: begin
                w_t   = {T_WIDTH{1'b0}};
                w_cnt = {DIV_WIDTH{1'b0}};
                if (r_gc == {GC_W{1'b0}}) begin
                    w_state     = ST_RUN;
                    w_sel       = slot_onehot(r_target);
                    w_slot      = r_target;
                    w_busy      = 1'b0;
                    w_req_ready = 1'b1;
                end else begin
                    w_gc = r_gc - {{(GC_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                // Recover from an impossible encoding to the reset state.
                w_state     = ST_RUN;
                w_sel       = 3'b001;
                w_t         = {T_WIDTH{1'b0}};
                w_busy      = 1'b0;
                w_req_ready = 1'b1;
                w_cnt       = {DIV_WIDTH{1'b0}};
                w_gc        = {GC_W{1'b0}};
                w_slot      = 2'd0;
                w_target    = 2'd0;
            end
        endcase

        if (w_enter_guard) begin
            w_state     = ST_GUARD;
            w_sel       = 3'b000;
            w_t         = {T_WIDTH{1'b0}};
            w_cnt       = {DIV_WIDTH{1'b0}};
            w_tick      = 1'b0;
            w_gc        = GC_W'(GUARD - 1);
            w_busy      = 1'b1;
            w_req_ready = 1'b0;
        end else begin
            w_busy = w_busy;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_sel       <= 3'b001;
            r_t         <= {T_WIDTH{1'b0}};
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_cnt       <= {DIV_WIDTH{1'b0}};
            r_gc        <= {GC_W{1'b0}};
            r_slot      <= 2'd0;
            r_target    <= 2'd0;
        end else begin
            r_state     <= w_state;
            r_sel       <= w_sel;
            r_t         <= w_t;
            r_tick      <= w_tick;
            r_busy      <= w_busy;
            r_req_ready <= w_req_ready;
            r_cnt       <= w_cnt;
            r_gc        <= w_gc;
            r_slot      <= w_slot;
            r_target    <= w_target;
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_sel       = r_sel;
    assign o_t         = r_t;
    assign o_tick      = r_tick;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_slot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_slot_scheduler
//
// Directed bench for slot_scheduler. The main instance uses the default
// widths. A second instance with a 4-bit sample counter shows that t wraps
// without causing a guard. Expected values are hand-derived cycle counts.
// ---------------------------------------------------------------------------
module tb_slot_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] div;
    logic        auto_en;
    logic [18:0] dwell;
    logic        req_valid;
    logic [1:0]  req_slot;
    logic        req_ready;
    logic [2:0]  sel;
    logic [18:0] t;
    logic        tick;
    logic        busy;

    logic        rst2;
    logic        req_ready2;
    logic [2:0]  sel2;
    logic [3:0]  t2;
    logic        tick2;
    logic        busy2;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] exp_rot [3];

    slot_scheduler #(.T_WIDTH(19), .DIV_WIDTH(16), .GUARD(4)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_div       (div),
        .i_auto_en   (auto_en),
        .i_dwell     (dwell),
        .i_req_valid (req_valid),
        .i_req_slot  (req_slot),
        .o_req_ready (req_ready),
        .o_sel       (sel),
        .o_t         (t),
        .o_tick      (tick),
        .o_busy      (busy)
    );

    slot_scheduler #(.T_WIDTH(4), .DIV_WIDTH(16), .GUARD(4)) u_dut_w4 (
        .i_clk       (clk),
        .i_rst       (rst2),
        .i_div       (16'd0),
        .i_auto_en   (1'b0),
        .i_dwell     (4'd0),
        .i_req_valid (1'b0),
        .i_req_slot  (2'd0),
        .o_req_ready (req_ready2),
        .o_sel       (sel2),
        .o_t         (t2),
        .o_tick      (tick2),
        .o_busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_sel"},   32'(sel),       32'd1);
        check_val({tag, "_t"},     32'(t),         32'd0);
        check_val({tag, "_tick"},  32'(tick),      32'd0);
        check_val({tag, "_busy"},  32'(busy),      32'd0);
        check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        exp_rot[0] = 3'b010;
        exp_rot[1] = 3'b100;
        exp_rot[2] = 3'b001;

        rst       = 1'b1;
        rst2      = 1'b1;
        div       = 16'd3;
        auto_en   = 1'b0;
        dwell     = 19'd0;
        req_valid = 1'b0;
        req_slot  = 2'd0;
        step(1);
        check_reset_state("rst");

        // 1: div=3 -> tick every 4 cycles
        rst = 1'b0;
        step(3);
        check_val("t1_notick", 32'(tick), 32'd0);
        check_val("t1_t0",     32'(t),    32'd0);
        step(1);
        check_val("t1_tick1",  32'(tick), 32'd1);
        check_val("t1_t1",     32'(t),    32'd1);
        step(1);
        check_val("t1_tickoff", 32'(tick), 32'd0);
        step(3);
        check_val("t1_tick2",  32'(tick), 32'd1);
        check_val("t1_t2",     32'(t),    32'd2);
        check_val("t1_sel",    32'(sel),  32'd1);

        // 2: request slot2 with div=0
        div       = 16'd0;
        req_valid = 1'b1;
        req_slot  = 2'd2;
        step(1);
        req_valid = 1'b0;
        check_val("t2_ready", 32'(req_ready), 32'd0);
        check_val("t2_busy",  32'(busy),      32'd1);
        check_val("t2_sel0",  32'(sel),       32'd0);
        check_val("t2_t0",    32'(t),         32'd0);
        step(3);
        check_val("t2_sel_g4", 32'(sel),  32'd0);
        check_val("t2_tick_g", 32'(tick), 32'd0);
        step(1);
        check_val("t2_sel100", 32'(sel),       32'd4);
        check_val("t2_busy0",  32'(busy),      32'd0);
        check_val("t2_ready1", 32'(req_ready), 32'd1);
        check_val("t2_t_exit", 32'(t),         32'd0);
        step(1);
        check_val("t2_ftick", 32'(tick), 32'd1);
        check_val("t2_ft1",   32'(t),    32'd1);

        // 3: illegal slot request is consumed without effect
        div       = 16'd100;
        req_valid = 1'b1;
        req_slot  = 2'd3;
        step(1);
        req_valid = 1'b0;
        check_val("t3_sel",   32'(sel),       32'd4);
        check_val("t3_t",     32'(t),         32'd1);
        check_val("t3_busy",  32'(busy),      32'd0);
        check_val("t3_ready", 32'(req_ready), 32'd1);
        step(1);
        check_val("t3_ready2", 32'(req_ready), 32'd1);
        check_val("t3_sel2",   32'(sel),       32'd4);

        // 4: auto rotation with dwell=5, div=0
        rst     = 1'b1;
        div     = 16'd0;
        auto_en = 1'b1;
        dwell   = 19'd5;
        step(1);
        rst = 1'b0;
        check_reset_state("t4_rst");
        for (int i = 0; i < 3; i++) begin
            step(4);
            check_val($sformatf("t4_t4_%0d", i), 32'(t), 32'd4);
            step(1);
            check_val($sformatf("t4_gsel_%0d", i), 32'(sel), 32'd0);
            check_val($sformatf("t4_gt_%0d", i),   32'(t),   32'd0);
            step(4);
            check_val($sformatf("t4_sel_%0d", i), 32'(sel), 32'(exp_rot[i]));
        end

        // 5: auto and req slot0 in the same cycle, from slot1
        step(9);
        check_val("t5_sel010", 32'(sel), 32'd2);
        step(4);
        check_val("t5_t4", 32'(t), 32'd4);
        req_valid = 1'b1;
        req_slot  = 2'd0;
        step(1);
        req_valid = 1'b0;
        check_val("t5_gsel", 32'(sel),  32'd0);
        check_val("t5_busy", 32'(busy), 32'd1);
        step(4);
        check_val("t5_sel001", 32'(sel), 32'd1);

        // Illegal request alongside auto: auto rotation still happens
        step(4);
        req_valid = 1'b1;
        req_slot  = 2'd3;
        step(1);
        req_valid = 1'b0;
        check_val("ill_auto_gsel", 32'(sel), 32'd0);
        step(4);
        check_val("ill_auto_sel", 32'(sel), 32'd2);
        auto_en = 1'b0;

        // 7: reset during the second guard cycle
        req_valid = 1'b1;
        req_slot  = 2'd2;
        step(1);
        check_val("t7_ready0", 32'(req_ready), 32'd0);
        step(1);
        check_val("t7_busy", 32'(busy), 32'd1);
        rst       = 1'b1;
        req_valid = 1'b0;
        step(1);
        rst = 1'b0;
        check_reset_state("t7");

        // Request held through guard is not taken again
        req_valid = 1'b1;
        req_slot  = 2'd1;
        step(1);
        check_val("hold_ready0", 32'(req_ready), 32'd0);
        step(4);
        check_val("hold_sel", 32'(sel),       32'd2);
        check_val("hold_rdy", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        step(1);
        check_val("hold_busy", 32'(busy), 32'd0);
        check_val("hold_sel2", 32'(sel),  32'd2);
        check_val("hold_t",    32'(t),    32'd1);

        // 6: 4-bit counter wraps with no guard
        rst2 = 1'b1;
        step(1);
        rst2 = 1'b0;
        step(15);
        check_val("t6_t15", 32'(t2), 32'd15);
        step(1);
        check_val("t6_wrap", 32'(t2),       32'd0);
        check_val("t6_sel",  32'(sel2),     32'd1);
        check_val("t6_busy", 32'(busy2),    32'd0);
        check_val("t6_tick", 32'(tick2),    32'd1);
        check_val("t6_rdy",  32'(req_ready2), 32'd1);
        step(1);
        check_val("t6_t1", 32'(t2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
